// File: rtl/fuel_level_conditioner_pkg.sv
// Shared constants for the fuel level conditioner: FSM encodings,
// hysteresis delta, default low-fuel threshold and a small helper.
package fuel_level_conditioner_pkg;

   localparam logic [1:0] ST_ACCUM  = 2'd0;
   localparam logic [1:0] ST_UPDATE = 2'd1;
   localparam logic [1:0] ST_FAULT  = 2'd2;

   localparam logic [3:0] HYST_DELTA  = 4'd2;
   localparam logic [3:0] LOW_LVL_DEF = 4'h2;

   function automatic logic [3:0] abs_diff4(
      input logic [3:0] a,
      input logic [3:0] b
   );
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/fuel_level_conditioner_if.sv
// Valid/ready sample bus from the fuel sensor front end.
// sample: raw sample, vld: sample valid, rdy: consumer can accept.
interface fuel_level_conditioner_if #(
   parameter int SAMPLE_W = 8
);

   logic [SAMPLE_W-1:0] sample;
   logic                vld;
   logic                rdy;

   modport master (
      output sample,
      output vld,
      input  rdy
   );

   modport slave (
      input  sample,
      input  vld,
      output rdy
   );

endinterface

// File: rtl/fuel_level_conditioner_blink.sv
// Low-fuel blink timer: counts BLINK_HALF cycles per half-period.
// clk/rst, en (count), restart (phase=1, count=0) -> phase.
module fuel_level_conditioner_blink #(
   parameter int BLINK_HALF = 500
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic phase
);

   localparam int CW =
      (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

   logic [CW-1:0] cnt;

   // Idle phase is 1 so the first low-fuel cycle shows "on".
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fuel_level_conditioner.sv
// Averages raw fuel samples, applies hysteresis, drives gauge level/mode.
// Clk_in/Rst_in, smp (sample bus slave), FLvl_out, BMode_out, FltFlag_out.
module fuel_level_conditioner
   import fuel_level_conditioner_pkg::*;
#(
   parameter int         SAMPLE_W    = 8,
   parameter int         AVG_LOG2    = 2,
   parameter int         TIMEOUT_CYC = 1000,
   parameter logic [3:0] LOW_LVL     = LOW_LVL_DEF,
   parameter int         BLINK_HALF  = 500
) (
   input  logic                     Clk_in,
   input  logic                     Rst_in,
   fuel_level_conditioner_if.slave  smp,
   output logic [3:0]               FLvl_out,
   output logic                     BMode_out,
   output logic                     FltFlag_out
);

   localparam int SUM_W = SAMPLE_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int TO_W  =
      (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TO_W-1:0]  TO_LAST  =
      TO_W'(TIMEOUT_CYC - 1);

   logic [1:0]       state;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             lvl_valid;

   logic       accept;
   logic [3:0] new_lvl;
   logic       load;
   logic       low;
   logic       phase;

   assign smp.rdy = !Rst_in && (state != ST_UPDATE);
   assign accept  = smp.vld && smp.rdy;

   // avg = sum >> AVG_LOG2, so avg's top nibble is sum's top nibble.
   assign new_lvl = sum[SUM_W-1 -: 4];

   assign load = !lvl_valid
              || (abs_diff4(new_lvl, FLvl_out) >= HYST_DELTA)
              || (new_lvl == 4'h0)
              || (new_lvl == 4'hF);

   // FAULT leaves sum/cnt at zero, so an accept there starts
   // a fresh window through the same path as ACCUM.
   always_ff @(posedge Clk_in) begin
      if (Rst_in) begin
         state       <= ST_ACCUM;
         sum         <= '0;
         cnt         <= '0;
         to_cnt      <= '0;
         lvl_valid   <= 1'b0;
         FLvl_out    <= 4'h0;
         FltFlag_out <= 1'b0;
      end else begin
         case (state)
            ST_UPDATE: begin
               if (load) begin
                  FLvl_out <= new_lvl;
               end
               lvl_valid <= 1'b1;
               sum       <= '0;
               cnt       <= '0;
               to_cnt    <= '0;
               state     <= ST_ACCUM;
            end
            ST_ACCUM, ST_FAULT: begin
               if (accept) begin
                  sum         <= sum + SUM_W'(smp.sample);
                  to_cnt      <= '0;
                  FltFlag_out <= 1'b0;
                  if (cnt == CNT_LAST) begin
                     state <= ST_UPDATE;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     state <= ST_ACCUM;
                  end
               end else if (state == ST_FAULT) begin
                  to_cnt <= '0;
               end else if (to_cnt == TO_LAST) begin
                  state       <= ST_FAULT;
                  FltFlag_out <= 1'b1;
                  sum         <= '0;
                  cnt         <= '0;
                  to_cnt      <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_ACCUM;
            end
         endcase
      end
   end

   assign low = lvl_valid && (FLvl_out <= LOW_LVL);

   // Fault freezes the blink so leaving it restarts at phase 1.
   fuel_level_conditioner_blink #(
      .BLINK_HALF(BLINK_HALF)
   ) u_blink (
      .clk    (Clk_in),
      .rst    (Rst_in),
      .en     (low),
      .restart(!low || FltFlag_out),
      .phase  (phase)
   );

   assign BMode_out = FltFlag_out || (low && phase);

endmodule

// File: tb/tb_fuel_level_conditioner.sv
// Randomized + directed bench for fuel_level_conditioner.
// Behavioural model compared every cycle, plus literal pins.
module tb_fuel_level_conditioner;

   localparam int TMO  = 20;
   localparam int HALF = 4;
   localparam int WIN  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] flvl;
   logic       bmode;
   logic       flt;

   int checks = 0;
   int errors = 0;

   fuel_level_conditioner_if #(.SAMPLE_W(8)) bus();

   fuel_level_conditioner #(
      .SAMPLE_W   (8),
      .AVG_LOG2   (2),
      .TIMEOUT_CYC(TMO),
      .LOW_LVL    (4'h2),
      .BLINK_HALF (HALF)
   ) dut (
      .Clk_in     (clk),
      .Rst_in     (rst),
      .smp        (bus),
      .FLvl_out   (flvl),
      .BMode_out  (bmode),
      .FltFlag_out(flt)
   );

   always #5 clk = ~clk;

   task automatic check(
      input string name,
      input int    act,
      input int    exp
   );
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: window of accepted samples, level, fault, idle count,
   // and the cycle at which the current low-fuel blink began.
   int   m_win[$];
   bit   m_upd, m_flt, m_valid, m_act;
   int   m_lvl, m_idle, m_cyc, m_start;
   bit   started = 1'b0;

   always @(posedge clk) begin
      int s, nw, d;
      bit act;
      started = 1'b1;
      if (rst) begin
         m_win.delete();
         m_upd   = 0;
         m_flt   = 0;
         m_valid = 0;
         m_lvl   = 0;
         m_idle  = 0;
      end else if (m_upd) begin
         s = 0;
         foreach (m_win[k]) s += m_win[k];
         nw = (s / WIN) / 16;
         d  = nw - m_lvl;
         if (d < 0) d = -d;
         if (!m_valid || d >= 2 || nw == 0 || nw == 15)
            m_lvl = nw;
         m_valid = 1;
         m_win.delete();
         m_upd  = 0;
         m_idle = 0;
      end else if (bus.vld) begin
         m_flt  = 0;
         m_idle = 0;
         m_win.push_back(int'(bus.sample));
         if (m_win.size() == WIN) m_upd = 1;
      end else if (!m_flt) begin
         m_idle++;
         if (m_idle == TMO) begin
            m_flt  = 1;
            m_idle = 0;
            m_win.delete();
         end
      end
      m_cyc++;
      act = m_valid && (m_lvl <= 2) && !m_flt;
      if (act && !m_act) m_start = m_cyc;
      m_act = act;
   end

   always @(negedge clk) begin
      int eb;
      if (started) begin
         if (m_flt) eb = 1;
         else if (m_act)
            eb = (((m_cyc - m_start) / HALF) % 2 == 0) ? 1 : 0;
         else eb = 0;
         check("rdy",   int'(bus.rdy), (!rst && !m_upd) ? 1 : 0);
         check("flvl",  int'(flvl),  m_lvl);
         check("flt",   int'(flt),   int'(m_flt));
         check("bmode", int'(bmode), eb);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      bus.vld = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] v);
      int   n = 0;
      logic a;
      bus.vld    = 1'b1;
      bus.sample = v;
      do begin
         a = bus.rdy;
         tick();
         n++;
      end while (!a && n < 50);
      if (!a) check("send_timeout", 0, 1);
      bus.vld = 1'b0;
   endtask

   task automatic send4(input logic [7:0] v);
      repeat (4) send(v);
   endtask

   initial begin
      int r;
      logic [7:0] v;
      bus.vld    = 1'b0;
      bus.sample = 8'h00;

      // reset
      rst = 1'b1;
      repeat (3) tick();
      check("pin_rst_flvl", int'(flvl), 0);
      check("pin_rst_bm",   int'(bmode), 0);
      check("pin_rst_flt",  int'(flt), 0);
      check("pin_rst_rdy",  int'(bus.rdy), 0);
      rst = 1'b0;
      #1;
      check("pin_rel_rdy",  int'(bus.rdy), 1);

      // first window loads unconditionally
      send4(8'hC0);
      check("pin_upd_rdy", int'(bus.rdy), 0);
      tick();
      check("pin_c0", int'(flvl), 'hC);
      check("pin_c0_bm", int'(bmode), 0);

      // hysteresis hold, full-scale, mixed average
      send4(8'hD0);
      tick();
      check("pin_hold", int'(flvl), 'hC);
      send4(8'hF0);
      tick();
      check("pin_full", int'(flvl), 'hF);
      send(8'h00); send(8'h00);
      send(8'hFF); send(8'hFF);
      tick();
      check("pin_avg7f", int'(flvl), 'h7);

      // low fuel blink
      send4(8'h10);
      tick();
      check("pin_low", int'(flvl), 'h1);
      check("pin_bl0", int'(bmode), 1);
      repeat (3) tick();
      check("pin_bl3", int'(bmode), 1);
      tick();
      check("pin_bl4", int'(bmode), 0);
      repeat (3) tick();
      check("pin_bl7", int'(bmode), 0);
      tick();
      check("pin_bl8", int'(bmode), 1);
      send4(8'h80);
      tick();
      check("pin_8", int'(flvl), 'h8);
      check("pin_8_bm", int'(bmode), 0);

      // timeout fault and recovery
      idle(TMO - 1);
      check("pin_pre_flt", int'(flt), 0);
      tick();
      check("pin_flt", int'(flt), 1);
      check("pin_flt_bm", int'(bmode), 1);
      check("pin_flt_lvl", int'(flvl), 'h8);
      send(8'h80);
      check("pin_flt_clr", int'(flt), 0);
      send(8'h80); send(8'h80); send(8'h80);
      tick();
      check("pin_rec", int'(flvl), 'h8);

      // reset mid-window, then sample on last idle cycle
      send(8'hF0); send(8'hF0);
      rst = 1'b1;
      tick();
      check("pin_mrst", int'(flvl), 0);
      rst = 1'b0;
      send4(8'h40);
      tick();
      check("pin_4", int'(flvl), 'h4);
      idle(TMO - 1);
      send(8'h40);
      check("pin_race", int'(flt), 0);
      send(8'h40); send(8'h40); send(8'h40);
      tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70) begin
            if ($urandom_range(0, 1) == 1)
               v = 8'($urandom_range(0, 255));
            else
               v = 8'($urandom_range(0, 63));
            send(v);
         end else if (r < 90) begin
            idle(int'($urandom_range(1, 4)));
         end else if (r < 96) begin
            idle(int'($urandom_range(TMO - 2, TMO + 4)));
         end else begin
            rst = 1'b1;
            repeat (int'($urandom_range(1, 2))) tick();
            rst = 1'b0;
         end
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
